// File: rtl/pll_mgmt_slave.sv
// rtl/pll_mgmt_slave.sv - Avalon-MM PLL reconfiguration responder with shadow dividers and lock model
module pll_mgmt_slave #(
    parameter int RECONF_CYCLES = 64,
    parameter int LOCK_DELAY    = 16
) (
    input  logic        mgmt_clk,
    input  logic        mgmt_reset_n,
    input  logic [5:0]  mgmt_address,
    input  logic        mgmt_write,
    input  logic [31:0] mgmt_writedata,
    input  logic        mgmt_read,
    output logic [31:0] mgmt_readdata,
    output logic        mgmt_waitrequest,
    output logic [8:0]  n_div,
    output logic [8:0]  m_div,
    output logic [8:0]  c0_div,
    output logic [31:0] m_frac,
    output logic        reconf_busy,
    output logic        locked,
    output logic        pll_changed
);
    localparam logic [15:0] BUSY_LAST = 16'(RECONF_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST = 16'(LOCK_DELAY - 1);

    localparam logic [5:0] A_MODE   = 6'd0;
    localparam logic [5:0] A_STATUS = 6'd1;
    localparam logic [5:0] A_START  = 6'd2;
    localparam logic [5:0] A_N      = 6'd3;
    localparam logic [5:0] A_M      = 6'd4;
    localparam logic [5:0] A_C      = 6'd5;
    localparam logic [5:0] A_MFRAC  = 6'd7;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      state, state_nxt;
    logic [15:0] busy_cnt, busy_cnt_nxt, lock_cnt;
    logic        mode, rd_phase;
    logic        busy, last_busy, stall, wr_acc, start_acc, rd_first;
    logic [17:0] n_sh, m_sh, c0_sh;
    logic [31:0] m_frac_sh, rd_mux;

    // Zero high+low means the full 256 count, as the counter wraps.
    function automatic logic [8:0] eff_div(input logic [17:0] w);
        logic [8:0] sum;
        sum = {1'b0, w[15:8]} + {1'b0, w[7:0]};
        if (w[16])
            eff_div = 9'd1;
        else if (sum == 9'd0)
            eff_div = 9'd256;
        else
            eff_div = sum;
    endfunction

    assign busy             = (state == S_BUSY);
    assign last_busy        = busy && (busy_cnt == BUSY_LAST);
    assign stall            = busy && !mode;
    // A read's first cycle always stalls while its register is captured.
    assign mgmt_waitrequest = stall || (mgmt_read && !mgmt_write && !rd_phase);
    assign wr_acc           = mgmt_write && !mgmt_waitrequest;
    assign start_acc        = wr_acc && (mgmt_address == A_START) && !busy;
    assign rd_first         = mgmt_read && !mgmt_write && !rd_phase && !stall;
    assign reconf_busy      = busy;
    assign pll_changed      = last_busy;

    always_comb begin
        state_nxt    = state;
        busy_cnt_nxt = busy_cnt;
        case (state)
            S_IDLE: begin
                if (start_acc) begin
                    state_nxt    = S_BUSY;
                    busy_cnt_nxt = 16'd0;
                end
            end
            S_BUSY: begin
                if (last_busy)
                    state_nxt = S_IDLE;
                else
                    busy_cnt_nxt = busy_cnt + 16'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (mgmt_address)
            A_MODE:   rd_mux = {31'd0, mode};
            A_STATUS: rd_mux = {31'd0, !busy};
            A_N:      rd_mux = {14'd0, n_sh};
            A_M:      rd_mux = {14'd0, m_sh};
            A_C:      rd_mux = {14'd0, c0_sh};
            A_MFRAC:  rd_mux = m_frac_sh;
            default:  rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge mgmt_clk) begin
        if (!mgmt_reset_n) begin
            state         <= S_IDLE;
            busy_cnt      <= 16'd0;
            mode          <= 1'b0;
            rd_phase      <= 1'b0;
            n_sh          <= 18'd0;
            m_sh          <= 18'd0;
            c0_sh         <= 18'd0;
            m_frac_sh     <= 32'd0;
            mgmt_readdata <= 32'd0;
            n_div         <= 9'd1;
            m_div         <= 9'd1;
            c0_div        <= 9'd1;
            m_frac        <= 32'd0;
            locked        <= 1'b0;
            lock_cnt      <= 16'd0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= busy_cnt_nxt;
            rd_phase <= rd_first;
            if (rd_first)
                mgmt_readdata <= rd_mux;
            if (wr_acc) begin
                case (mgmt_address)
                    A_MODE:  mode <= mgmt_writedata[0];
                    A_N:     n_sh <= mgmt_writedata[17:0];
                    A_M:     m_sh <= mgmt_writedata[17:0];
                    A_C: begin
                        if (mgmt_writedata[22:18] == 5'd0)
                            c0_sh <= mgmt_writedata[17:0];
                    end
                    A_MFRAC: m_frac_sh <= mgmt_writedata;
                    default: ;
                endcase
            end
            // Commit samples shadows before any write accepted on the same edge.
            if (last_busy) begin
                n_div  <= eff_div(n_sh);
                m_div  <= eff_div(m_sh);
                c0_div <= eff_div(c0_sh);
                m_frac <= m_frac_sh;
            end
            if (busy || start_acc) begin
                locked   <= 1'b0;
                lock_cnt <= 16'd0;
            end else if (!locked) begin
                if (lock_cnt == LOCK_LAST)
                    locked <= 1'b1;
                else
                    lock_cnt <= lock_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_pll_mgmt_slave.sv
// tb/tb_pll_mgmt_slave.sv - randomized self-checking bench for pll_mgmt_slave against a transaction-level model
module tb_pll_mgmt_slave;
    localparam int R  = 64;
    localparam int LD = 16;

    logic        mgmt_clk = 1'b0;
    logic        mgmt_reset_n;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_read;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic [8:0]  n_div, m_div, c0_div;
    logic [31:0] m_frac;
    logic        reconf_busy, locked, pll_changed;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 mgmt_clk = ~mgmt_clk;
    always @(posedge mgmt_clk) cyc++;

    pll_mgmt_slave #(.RECONF_CYCLES(R), .LOCK_DELAY(LD)) dut (
        .mgmt_clk(mgmt_clk), .mgmt_reset_n(mgmt_reset_n), .mgmt_address(mgmt_address),
        .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata), .mgmt_read(mgmt_read),
        .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest),
        .n_div(n_div), .m_div(m_div), .c0_div(c0_div), .m_frac(m_frac),
        .reconf_busy(reconf_busy), .locked(locked), .pll_changed(pll_changed)
    );

    // Observed busy runs, commit pulses and lock gaps
    int   run_len = 0, pulse_pos = 0, pulse_cnt = 0;
    int   last_run = 0, last_pulse_pos = 0, last_pulse_cnt = 0, runs_done = 0;
    int   pulse_total = 0, stray_pulse = 0, lock_in_busy = 0;
    int   idle_unlocked = 0, last_lock_gap = -1, lock_events = 0;
    logic prev_locked = 1'b0;

    always @(negedge mgmt_clk) begin
        if (pll_changed) begin
            pulse_total++;
            if (!reconf_busy) stray_pulse++;
        end
        if (reconf_busy && locked) lock_in_busy++;
        if (reconf_busy) begin
            run_len++;
            if (pll_changed) begin
                pulse_cnt++;
                pulse_pos = run_len;
            end
        end else if (run_len != 0) begin
            last_run       = run_len;
            last_pulse_pos = pulse_pos;
            last_pulse_cnt = pulse_cnt;
            runs_done++;
            run_len   = 0;
            pulse_pos = 0;
            pulse_cnt = 0;
        end
        if (!mgmt_reset_n || reconf_busy)
            idle_unlocked = 0;
        else if (!locked)
            idle_unlocked++;
        else if (!prev_locked) begin
            last_lock_gap = idle_unlocked;
            lock_events++;
        end
        prev_locked = locked;
    end

    // Reference model: register file plus a pending commit scheduled at an absolute cycle
    logic [31:0] s_n, s_m, s_c0, s_frac;
    logic        s_mode;
    int          e_n, e_m, e_c0;
    logic [31:0] e_frac;
    bit          pend;
    int          pend_c;

    function automatic int exp_div(input logic [31:0] w);
        int s;
        if (w[16]) return 1;
        s = int'(w[15:8]) + int'(w[7:0]);
        return (s == 0) ? 256 : s;
    endfunction

    function automatic void mdl_reset();
        s_n = 0; s_m = 0; s_c0 = 0; s_frac = 0; s_mode = 1'b0;
        e_n = 1; e_m = 1; e_c0 = 1; e_frac = 0;
        pend = 1'b0; pend_c = 0;
    endfunction

    function automatic void mdl_commit();
        e_n = exp_div(s_n); e_m = exp_div(s_m); e_c0 = exp_div(s_c0); e_frac = s_frac;
        pend = 1'b0;
    endfunction

    function automatic void mdl_sync(input int now);
        if (pend && now > pend_c) mdl_commit();
    endfunction

    function automatic void mdl_write(input int w, input logic [5:0] a, input logic [31:0] d);
        bit was_busy;
        was_busy = pend && (w <= pend_c);
        if (pend && w >= pend_c) mdl_commit();
        case (a)
            6'd0: s_mode = d[0];
            6'd2: if (!was_busy) begin pend = 1'b1; pend_c = w + R; end
            6'd3: s_n = d & 32'h3FFFF;
            6'd4: s_m = d & 32'h3FFFF;
            6'd5: if (d[22:18] == 5'd0) s_c0 = d & 32'h3FFFF;
            6'd7: s_frac = d;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] mdl_read(input logic [5:0] a, input int cap);
        mdl_sync(cap);
        case (a)
            6'd0: return {31'd0, s_mode};
            6'd1: return {31'd0, !(pend && cap <= pend_c)};
            6'd3: return s_n;
            6'd4: return s_m;
            6'd5: return s_c0;
            6'd7: return s_frac;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_cnt();
        logic [31:0] w;
        w = $urandom() & 32'h3FFFF;
        if ($urandom_range(0, 3) == 0) w[15:0] = 16'd0;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge mgmt_clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, output int stalls);
        int acc;
        mgmt_address = a; mgmt_writedata = d; mgmt_write = 1'b1; stalls = 0;
        @(negedge mgmt_clk);
        while (mgmt_waitrequest && stalls < 1000) begin stalls++; @(negedge mgmt_clk); end
        acc = cyc;
        @(posedge mgmt_clk); #1;
        mgmt_write = 1'b0;
        mdl_write(acc, a, d);
    endtask

    logic [31:0] last_rd = 32'd0;

    task automatic rd_chk(input logic [5:0] a, input string tag, output logic [31:0] d, output int stalls);
        int cap;
        mgmt_address = a; mgmt_read = 1'b1; stalls = 0;
        @(negedge mgmt_clk);
        while (mgmt_waitrequest && stalls < 1000) begin stalls++; @(negedge mgmt_clk); end
        cap = cyc - 1;
        d = mgmt_readdata;
        @(posedge mgmt_clk); #1;
        mgmt_read = 1'b0;
        last_rd = d;
        chk(tag, d, mdl_read(a, cap));
    endtask

    task automatic wait_run(input int r0);
        int n;
        n = 0;
        while (runs_done == r0 && n < 3000) begin @(posedge mgmt_clk); n++; end
        #1;
        chk("run_seen", 32'(runs_done != r0), 1);
    endtask

    task automatic wait_lock(input int l0);
        int n;
        n = 0;
        while (lock_events == l0 && n < 3000) begin @(posedge mgmt_clk); n++; end
        #1;
        chk("lock_seen", 32'(lock_events != l0), 1);
    endtask

    task automatic chk_outs(input string tag);
        mdl_sync(cyc);
        chk({tag, "_n_div"}, 32'(n_div), e_n);
        chk({tag, "_m_div"}, 32'(m_div), e_m);
        chk({tag, "_c0_div"}, 32'(c0_div), e_c0);
        chk({tag, "_m_frac"}, m_frac, e_frac);
    endtask

    task automatic chk_run(input string tag);
        chk({tag, "_busy_len"}, last_run, R);
        chk({tag, "_pulse_pos"}, last_pulse_pos, R);
        chk({tag, "_pulse_cnt"}, last_pulse_cnt, 1);
    endtask

    initial begin
        int s, r0, l0, p0, zeros, n, acc;
        logic [31:0] d, x;
        bit got;

        mgmt_reset_n = 1'b0; mgmt_address = 6'd0; mgmt_write = 1'b0;
        mgmt_writedata = 32'd0; mgmt_read = 1'b0;
        mdl_reset();
        idle(3);
        @(negedge mgmt_clk);
        chk("rst_readdata", mgmt_readdata, 0);
        chk("rst_waitreq", 32'(mgmt_waitrequest), 0);
        chk("rst_busy", 32'(reconf_busy), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_pll_changed", 32'(pll_changed), 0);
        chk_outs("rst");
        l0 = lock_events;
        @(posedge mgmt_clk); #1;
        mgmt_reset_n = 1'b1;
        wait_lock(l0);
        chk("rst_lock_gap", last_lock_gap, LD);

        // NTSC sequence, waitrequest mode
        wr(0, 0, s);
        chk("wr_stall_idle", s, 0);
        wr(3, 32'h00010000, s); wr(4, 32'h00000404, s); wr(5, 32'h00000505, s); wr(7, 32'h9745BF27, s);
        r0 = runs_done; l0 = lock_events;
        wr(2, 0, s);
        wait_run(r0);
        chk_run("ntsc");
        wait_lock(l0);
        chk("ntsc_lock_gap", last_lock_gap, LD);
        chk_outs("ntsc");
        chk("ntsc_n_lit", 32'(n_div), 1);
        chk("ntsc_m_lit", 32'(m_div), 8);
        chk("ntsc_c0_lit", 32'(c0_div), 10);
        chk("ntsc_frac_lit", m_frac, 32'h9745BF27);

        // PAL sequence
        wr(5, 32'h00020504, s); wr(7, 32'hA3D709E8, s);
        r0 = runs_done; l0 = lock_events;
        wr(2, 0, s);
        wait_run(r0);
        chk_run("pal");
        wait_lock(l0);
        chk_outs("pal");
        chk("pal_c0_lit", 32'(c0_div), 9);
        rd_chk(5, "pal_rd_c", d, s);
        chk("pal_rd_c_lit", d, 32'h00020504);
        chk("rd_latency", s, 1);

        // Waitrequest mode: write right after start stalls for the whole reconfiguration
        r0 = runs_done; l0 = lock_events;
        wr(2, 0, s);
        wr(3, rnd_cnt(), s);
        chk("wrq_stall", s, R);
        wait_lock(l0);
        chk("wrq_lock_gap", last_lock_gap, LD);
        chk_outs("wrq");

        // Polling mode status
        wr(0, 1, s);
        rd_chk(0, "rd_mode", d, s);
        r0 = runs_done; l0 = lock_events;
        wr(2, 0, s);
        zeros = 0; got = 1'b0; n = 0;
        while (!got && n < 100) begin
            rd_chk(1, "poll_status", d, s);
            if (d[0]) got = 1'b1; else zeros++;
            n++;
        end
        chk("poll_zero_reads", zeros, R / 2);
        wait_run(r0);
        chk_run("poll");
        wait_lock(l0);

        // Second start while busy ignored; mid-busy M write commits
        r0 = runs_done; l0 = lock_events;
        wr(2, 0, s);
        idle(10);
        wr(2, 0, s);
        chk("poll_wr_nostall", s, 0);
        wr(4, 32'h00000303, s);
        wait_run(r0);
        chk_run("restart");
        wait_lock(l0);
        chk_outs("restart");
        chk("restart_m_lit", 32'(m_div), 6);

        // C index 1 discarded; M of zero divides by 256
        wr(5, 32'h00040505, s);
        rd_chk(5, "c_idx1_rd", d, s);
        wr(4, 32'h00000000, s);
        r0 = runs_done; l0 = lock_events;
        wr(2, 0, s);
        wait_run(r0);
        wait_lock(l0);
        chk_outs("m_zero");
        chk("m_zero_lit", 32'(m_div), 256);

        // Simultaneous read and write: write wins, readdata holds
        rd_chk(7, "pre_rw_rd", d, s);
        x = rnd_cnt();
        mgmt_address = 6'd3; mgmt_writedata = x; mgmt_write = 1'b1; mgmt_read = 1'b1;
        @(negedge mgmt_clk);
        chk("rw_waitreq", 32'(mgmt_waitrequest), 0);
        acc = cyc;
        @(posedge mgmt_clk); #1;
        mgmt_write = 1'b0; mgmt_read = 1'b0;
        mdl_write(acc, 6'd3, x);
        @(negedge mgmt_clk);
        chk("rw_rdata_hold", mgmt_readdata, last_rd);
        @(posedge mgmt_clk); #1;
        rd_chk(3, "rw_rd_n", d, s);

        // Randomized shadow programming, mode and mid-busy traffic
        for (int i = 0; i < 6; i++) begin
            wr(0, $urandom_range(0, 1), s);
            wr(3, rnd_cnt(), s); wr(4, rnd_cnt(), s); wr(5, rnd_cnt(), s); wr(7, $urandom(), s);
            wr(6'($urandom_range(8, 63)), $urandom(), s);
            r0 = runs_done; l0 = lock_events;
            wr(2, $urandom(), s);
            idle($urandom_range(0, 40));
            wr(4, rnd_cnt(), s);
            rd_chk(6'($urandom_range(0, 63)), "rand_rd", d, s);
            wait_run(r0);
            wait_lock(l0);
            chk("rand_busy_len", last_run, R);
            chk_outs("rand");
            rd_chk(5, "rand_rd_c", d, s);
        end

        // Reset in the middle of a reconfiguration aborts it
        wr(0, 1, s);
        wr(3, 32'h00000202, s); wr(4, 32'h00000707, s); wr(7, 32'h12345678, s);
        p0 = pulse_total;
        wr(2, 0, s);
        n = 0; zeros = 0;
        while (n < 30 && zeros < 200) begin
            @(negedge mgmt_clk);
            if (reconf_busy) n++;
            zeros++;
        end
        @(posedge mgmt_clk); #1;
        mgmt_reset_n = 1'b0;
        @(posedge mgmt_clk); #1;
        @(negedge mgmt_clk);
        mdl_reset();
        chk("abort_busy", 32'(reconf_busy), 0);
        chk("abort_locked", 32'(locked), 0);
        chk_outs("abort");
        l0 = lock_events;
        @(posedge mgmt_clk); #1;
        mgmt_reset_n = 1'b1;
        wait_lock(l0);
        chk("abort_lock_gap", last_lock_gap, LD);
        chk("abort_no_commit", pulse_total, p0);
        chk_outs("abort_after");
        rd_chk(3, "abort_rd_n", d, s);

        chk("stray_pulses", stray_pulse, 0);
        chk("locked_during_busy", lock_in_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
